// File: rtl/ula_issue_stage.sv
// ALU issue stage: decodes ID-stage instructions into ALUControl plus operands and
// presents them to the EX-stage ALU through a registered valid/ready stage with a skid entry.
module ula_issue_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [2:0]           funct,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [IMM_WIDTH-1:0] imediato,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           ALUControl,
  output logic [WIDTH-1:0]     entrada1,
  output logic [WIDTH-1:0]     entrada2,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam int EXT = WIDTH - IMM_WIDTH;

  logic [WIDTH-1:0] imm_sext, imm_zext;
  logic [2:0]       dec_ctrl;
  logic [WIDTH-1:0] dec_b;
  logic             dec_legal;

  logic             skid_valid;
  logic [2:0]       skid_ctrl;
  logic [WIDTH-1:0] skid_a, skid_b;

  logic accept, acc_legal, acc_illegal;
  logic out_load, skid_write, skid_valid_nxt;

  assign imm_sext = {{EXT{imediato[IMM_WIDTH-1]}}, imediato};
  assign imm_zext = {{EXT{1'b0}}, imediato};

  always_comb begin
    dec_ctrl  = 3'b000;
    dec_b     = rt_data;
    dec_legal = 1'b1;
    case (opcode)
      4'b0000: begin
        dec_ctrl = funct;
        if (funct > 3'b100) dec_legal = 1'b0;
      end
      4'b0001: begin dec_ctrl = 3'b010; dec_b = imm_sext; end
      4'b0010: begin dec_ctrl = 3'b000; dec_b = imm_zext; end
      4'b0011: begin dec_ctrl = 3'b001; dec_b = imm_zext; end
      4'b0100: begin dec_ctrl = 3'b100; dec_b = imm_sext; end
      4'b0101: begin dec_ctrl = 3'b011; dec_b = rt_data;  end
      4'b0110,
      4'b0111: begin dec_ctrl = 3'b010; dec_b = imm_sext; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign acc_legal   = accept && dec_legal;
  assign acc_illegal = accept && !dec_legal;
  assign out_load    = !out_valid || out_ready;
  // The skid entry catches a legal input whenever OUT cannot take it directly.
  assign skid_write  = acc_legal && ((out_valid && !out_ready) || (out_load && skid_valid));

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (skid_write)                   skid_valid_nxt = 1'b1;
    else if (out_load && skid_valid)  skid_valid_nxt = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
      ALUControl    <= 3'b000;
      entrada1      <= '0;
      entrada2      <= '0;
      skid_valid    <= 1'b0;
      skid_ctrl     <= 3'b000;
      skid_a        <= '0;
      skid_b        <= '0;
      illegal_instr <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      in_ready      <= 1'b1;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= acc_illegal;
      if (acc_illegal && illegal_count != '1)
        illegal_count <= illegal_count + CNT_WIDTH'(1);
      if (out_load) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          ALUControl <= skid_ctrl;
          entrada1   <= skid_a;
          entrada2   <= skid_b;
        end else if (acc_legal) begin
          out_valid  <= 1'b1;
          ALUControl <= dec_ctrl;
          entrada1   <= rs_data;
          entrada2   <= dec_b;
        end else begin
          out_valid  <= 1'b0;
        end
      end
      if (skid_write) begin
        skid_ctrl <= dec_ctrl;
        skid_a    <= rs_data;
        skid_b    <= dec_b;
      end
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ula_issue_stage.sv
// Directed bench for ula_issue_stage: decode, skid ordering, illegal handling, flush, reset.
module tb_ula_issue_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, illegal_instr;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imediato;
  logic [2:0]  ALUControl;
  logic [31:0] entrada1, entrada2;
  logic [7:0]  illegal_count;

  int n_checks = 0;
  int n_pass   = 0;

  ula_issue_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .imediato(imediato),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUControl(ALUControl), .entrada1(entrada1), .entrada2(entrada2),
    .illegal_instr(illegal_instr), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    in_valid = v; opcode = op; funct = fn; rs_data = rs; rt_data = rt; imediato = imm;
  endtask

  task automatic check_out(input string tag, input logic [2:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".ctrl"},  32'(ALUControl), 32'(ctrl));
    check({tag, ".a"},     entrada1, a);
    check({tag, ".b"},     entrada2, b);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready), 32'd1);
    check({tag, ".ctrl"},      32'(ALUControl), 32'd0);
    check({tag, ".a"},         entrada1, 32'd0);
    check({tag, ".b"},         entrada2, 32'd0);
    check({tag, ".ill"},       32'(illegal_instr), 32'd0);
    check({tag, ".cnt"},       32'(illegal_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 16'd0);
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;

    // Decode of each format with out_ready held high
    drive(1'b1, 4'b0000, 3'b010, 32'd5, 32'd7, 16'd0);
    tick();
    check_out("add", 3'b010, 32'd5, 32'd7);
    check("add.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 4'b0001, 3'b000, 32'd3, 32'd99, 16'hFFFE);
    tick();
    check_out("addi", 3'b010, 32'd3, 32'hFFFFFFFE);
    drive(1'b1, 4'b0010, 3'b000, 32'd4, 32'd99, 16'hFFFE);
    tick();
    check_out("andi", 3'b000, 32'd4, 32'h0000FFFE);
    drive(1'b1, 4'b0011, 3'b000, 32'd6, 32'd99, 16'h8001);
    tick();
    check_out("ori", 3'b001, 32'd6, 32'h00008001);
    drive(1'b1, 4'b0100, 3'b000, 32'd8, 32'd99, 16'h8000);
    tick();
    check_out("slti", 3'b100, 32'd8, 32'hFFFF8000);
    drive(1'b1, 4'b0101, 3'b000, 32'd10, 32'd9, 16'hFFFF);
    tick();
    check_out("beq", 3'b011, 32'd10, 32'd9);
    drive(1'b1, 4'b0111, 3'b000, 32'd12, 32'd99, 16'h0004);
    tick();
    check_out("sw", 3'b010, 32'd12, 32'd4);
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("idle.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: SUB held in OUT, OR in SKID, SLT waits
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 3'b011, 32'd1, 32'd2, 16'd0);
    tick();
    check_out("sub", 3'b011, 32'd1, 32'd2);
    check("sub.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 4'b0000, 3'b001, 32'd3, 32'd4, 16'd0);
    tick();
    check_out("hold1", 3'b011, 32'd1, 32'd2);
    check("hold1.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 4'b0000, 3'b100, 32'd5, 32'd6, 16'd0);
    tick();
    check_out("hold2", 3'b011, 32'd1, 32'd2);
    check("hold2.in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check_out("or", 3'b001, 32'd3, 32'd4);
    check("or.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("slt", 3'b100, 32'd5, 32'd6);
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Flush with OUT and SKID full plus a pending input
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 3'b010, 32'd20, 32'd1, 16'd0);
    tick();
    drive(1'b1, 4'b0000, 3'b001, 32'd21, 32'd1, 16'd0);
    tick();
    check("fill.in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 4'b0000, 3'b000, 32'd22, 32'd1, 16'd0);
    tick();
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    // Legal input accepted on a flush cycle is discarded
    drive(1'b1, 4'b0000, 3'b010, 32'd23, 32'd1, 16'd0);
    tick();
    check("flush2.out_valid", 32'(out_valid), 32'd0);
    // Illegal input on a flush cycle leaves no pulse and no count
    drive(1'b1, 4'b1111, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("flush_ill.pulse", 32'(illegal_instr), 32'd0);
    check("flush_ill.cnt", 32'(illegal_count), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("postflush.out_valid", 32'(out_valid), 32'd0);
    tick();
    check("postflush2.out_valid", 32'(out_valid), 32'd0);

    // Illegal encodings
    drive(1'b1, 4'b1001, 3'b000, 32'd1, 32'd1, 16'd0);
    tick();
    check("ill1.pulse", 32'(illegal_instr), 32'd1);
    check("ill1.cnt", 32'(illegal_count), 32'd1);
    check("ill1.out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 4'b0000, 3'b111, 32'd1, 32'd1, 16'd0);
    tick();
    check("ill2.pulse", 32'(illegal_instr), 32'd1);
    check("ill2.cnt", 32'(illegal_count), 32'd2);
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("ill_gap.pulse", 32'(illegal_instr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 4'b0000, 3'(5 + (i % 3)), 32'd0, 32'd0, 16'd0);
      tick();
      check("illn.pulse", 32'(illegal_instr), 32'd1);
      check("illn.out_valid", 32'(out_valid), 32'd0);
    end
    check("sat.cnt", 32'(illegal_count), 32'd255);
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("sat2.cnt", 32'(illegal_count), 32'd255);
    check("sat2.pulse", 32'(illegal_instr), 32'd0);

    // Reset while busy and stalled
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 3'b010, 32'd30, 32'd31, 16'd0);
    tick();
    drive(1'b1, 4'b0000, 3'b011, 32'd32, 32'd33, 16'd0);
    tick();
    check("busy.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1; flush = 1'b1;
    tick();
    check_reset_state("busy_reset");
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0, 16'd0);
    tick();
    check("after_reset.out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
